// File: rtl/four_func_core.sv
// four_func_core: operand entry FSM with 1-cycle add/sub and WIDTH-cycle shift-add multiply / restoring divide
module four_func_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   sw,
    input  logic [1:0]         op,
    input  logic               enter,
    input  logic               clear,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_DONE} state_t;
    state_t state;
    logic enterQ, press, last, bBit, aBit, geq;
    logic [1:0] opr;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] a, b, rem, quo, remNext, quoNext, bSh, aSh;
    logic [WIDTH:0] trial;
    logic [2*WIDTH-1:0] res, prod, prodNext, sum, diff;
    always_comb begin
        press    = enter & ~enterQ;
        last     = count == CW'(WIDTH - 1);
        bSh      = b >> count;
        aSh      = a << count;
        bBit     = bSh[0];
        aBit     = aSh[WIDTH-1];
        prodNext = prod + (bBit ? ({{WIDTH{1'b0}}, a} << count) : '0);
        trial    = {rem, aBit};
        geq      = trial >= {1'b0, b};
        remNext  = geq ? WIDTH'(trial - {1'b0, b}) : trial[WIDTH-1:0];
        quoNext  = WIDTH'({quo, geq});
        sum      = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
        diff     = a >= b ? {WIDTH'(0), a - b} : {WIDTH'(1), b - a};
        result   = state == S_A ? {WIDTH'(0), sw} : state == S_B ? {a, sw} : state == S_EXEC ? {a, b} : res;
        busy     = state == S_EXEC;
        done     = state == S_DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_A;
            enterQ <= 1'b1;
            a      <= '0;
            b      <= '0;
            opr    <= '0;
            count  <= '0;
            res    <= '0;
            err    <= 1'b0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
        end else begin
            enterQ <= enter;
            if (clear) begin
                state <= S_A;
                a     <= '0;
                b     <= '0;
                res   <= '0;
                err   <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    S_A: if (press) begin
                        a     <= sw;
                        state <= S_B;
                    end
                    S_B: if (press) begin
                        b     <= sw;
                        opr   <= op;
                        count <= '0;
                        prod  <= '0;
                        rem   <= '0;
                        quo   <= '0;
                        state <= S_EXEC;
                    end
                    S_EXEC: if (!opr[1]) begin
                        res   <= opr[0] ? diff : sum;
                        err   <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                        prod  <= prodNext;
                        rem   <= remNext;
                        quo   <= quoNext;
                        if (last) begin
                            // divide by zero still iterates, then saturates the display
                            res   <= opr[0] ? (b == '0 ? '1 : {quoNext, remNext}) : prodNext;
                            err   <= opr[0] & (b == '0);
                            state <= S_DONE;
                        end
                    end
                    S_DONE: if (press) begin
                        a     <= '0;
                        b     <= '0;
                        err   <= 1'b0;
                        state <= S_A;
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end
endmodule
